// File: rtl/pinwheel_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pinwheel_bus_arbiter: two-master TileLink-UL arbiter that shares one bus    |
// | slave between the core (m0) and a debug/loader master (m1).                |
// | m1 has a starvation guard. An in-order source FIFO routes D responses.      |
// | Optional: PINWHEEL_ARB_STATS_EN adds saturating grant statistics outputs.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module pinwheel_bus_arbiter #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int STARVE_LIMIT    = 4,
`ifdef PINWHEEL_ARB_STATS_EN
   parameter int CNT_WIDTH       = 16,
`endif
   parameter int SRC_WIDTH       = 2
) (
   input  logic                 clock,
   input  logic                 reset_n,
   // m0: core
   input  logic                 m0_a_valid_i,
   input  logic [2:0]           m0_a_opcode_i,
   input  logic [1:0]           m0_a_size_i,
   input  logic [SRC_WIDTH-1:0] m0_a_source_i,
   input  logic [31:0]          m0_a_address_i,
   input  logic [3:0]           m0_a_mask_i,
   input  logic [31:0]          m0_a_data_i,
   output logic                 m0_a_ready_o,
   output logic                 m0_d_valid_o,
   output logic [2:0]           m0_d_opcode_o,
   output logic [1:0]           m0_d_size_o,
   output logic [SRC_WIDTH-1:0] m0_d_source_o,
   output logic [31:0]          m0_d_data_o,
   output logic                 m0_d_error_o,
   // m1: debug/loader
   input  logic                 m1_a_valid_i,
   input  logic [2:0]           m1_a_opcode_i,
   input  logic [1:0]           m1_a_size_i,
   input  logic [SRC_WIDTH-1:0] m1_a_source_i,
   input  logic [31:0]          m1_a_address_i,
   input  logic [3:0]           m1_a_mask_i,
   input  logic [31:0]          m1_a_data_i,
   output logic                 m1_a_ready_o,
   output logic                 m1_d_valid_o,
   output logic [2:0]           m1_d_opcode_o,
   output logic [1:0]           m1_d_size_o,
   output logic [SRC_WIDTH-1:0] m1_d_source_o,
   output logic [31:0]          m1_d_data_o,
   output logic                 m1_d_error_o,
   // slave
   output logic                 slv_a_valid_o,
   output logic [2:0]           slv_a_opcode_o,
   output logic [1:0]           slv_a_size_o,
   output logic [SRC_WIDTH-1:0] slv_a_source_o,
   output logic [31:0]          slv_a_address_o,
   output logic [3:0]           slv_a_mask_o,
   output logic [31:0]          slv_a_data_o,
   input  logic                 slv_a_ready_i,
   input  logic                 slv_d_valid_i,
   input  logic [2:0]           slv_d_opcode_i,
   input  logic [1:0]           slv_d_size_i,
   input  logic [31:0]          slv_d_data_i,
   input  logic                 slv_d_error_i,
`ifdef PINWHEEL_ARB_STATS_EN
   output logic [CNT_WIDTH-1:0] stat_gnt0_o,
   output logic [CNT_WIDTH-1:0] stat_gnt1_o,
   output logic [CNT_WIDTH-1:0] stat_force_o,
`endif
   output logic                 busy_o,
   output logic                 err_spurious_o
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

   logic [CNT_W-1:0]     count_q, count_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [STV_W-1:0]     starve_q, starve_d;
   logic                 err_q, err_d;
   logic                 fifo_idx_q [MAX_OUTSTANDING];
   logic [SRC_WIDTH-1:0] fifo_src_q [MAX_OUTSTANDING];

   logic can_issue, force_m1, gnt0, gnt1, a_fire, fifo_empty, pop, head_idx;

   // Grants are gated by reset_n so every request-side output drops the moment reset asserts.
   always_comb begin
      can_issue = reset_n & slv_a_ready_i & (count_q < CNT_MAX);
      force_m1  = (starve_q == STV_MAX) & m1_a_valid_i;
      gnt1      = can_issue & m1_a_valid_i & (force_m1 | ~m0_a_valid_i);
      gnt0      = can_issue & m0_a_valid_i & ~gnt1;
      a_fire    = gnt0 | gnt1;
      fifo_empty = (count_q == '0);
      pop       = slv_d_valid_i & ~fifo_empty;
      head_idx  = fifo_idx_q[rd_ptr_q];
   end

   always_comb begin
      m0_a_ready_o    = gnt0;
      m1_a_ready_o    = gnt1;
      slv_a_valid_o   = a_fire;
      slv_a_source_o  = SRC_WIDTH'(gnt1);
      slv_a_opcode_o  = gnt1 ? m1_a_opcode_i  : m0_a_opcode_i;
      slv_a_size_o    = gnt1 ? m1_a_size_i    : m0_a_size_i;
      slv_a_address_o = gnt1 ? m1_a_address_i : m0_a_address_i;
      slv_a_mask_o    = gnt1 ? m1_a_mask_i    : m0_a_mask_i;
      slv_a_data_o    = gnt1 ? m1_a_data_i    : m0_a_data_i;

      m0_d_valid_o  = pop & ~head_idx;
      m0_d_opcode_o = slv_d_opcode_i;
      m0_d_size_o   = slv_d_size_i;
      m0_d_source_o = fifo_src_q[rd_ptr_q];
      m0_d_data_o   = slv_d_data_i;
      m0_d_error_o  = slv_d_error_i;
      m1_d_valid_o  = pop & head_idx;
      m1_d_opcode_o = slv_d_opcode_i;
      m1_d_size_o   = slv_d_size_i;
      m1_d_source_o = fifo_src_q[rd_ptr_q];
      m1_d_data_o   = slv_d_data_i;
      m1_d_error_o  = slv_d_error_i;

      busy_o         = ~fifo_empty;
      err_spurious_o = err_q;
   end

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      starve_d = '0;
      err_d    = err_q | (slv_d_valid_i & fifo_empty);
      if (a_fire) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({a_fire, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (m1_a_valid_i && !gnt1) begin
         starve_d = (starve_q == STV_MAX) ? starve_q : starve_q + STV_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         starve_q <= '0;
         err_q    <= 1'b0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         starve_q <= starve_d;
         err_q    <= err_d;
      end
   end

   // Entry payload needs no reset: it is only read while count_q marks it valid.
   always_ff @(posedge clock) begin
      if (a_fire) begin
         fifo_idx_q[wr_ptr_q] <= gnt1;
         fifo_src_q[wr_ptr_q] <= gnt1 ? m1_a_source_i : m0_a_source_i;
      end
   end

`ifdef PINWHEEL_ARB_STATS_EN
   logic [CNT_WIDTH-1:0] stat_gnt0_q, stat_gnt1_q, stat_force_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stat_gnt0_q  <= '0;
         stat_gnt1_q  <= '0;
         stat_force_q <= '0;
      end else begin
         if (gnt0 && !(&stat_gnt0_q)) stat_gnt0_q <= stat_gnt0_q + CNT_WIDTH'(1);
         if (gnt1 && !(&stat_gnt1_q)) stat_gnt1_q <= stat_gnt1_q + CNT_WIDTH'(1);
         if (gnt1 && force_m1 && !(&stat_force_q)) stat_force_q <= stat_force_q + CNT_WIDTH'(1);
      end
   end

   assign stat_gnt0_o  = stat_gnt0_q;
   assign stat_gnt1_o  = stat_gnt1_q;
   assign stat_force_o = stat_force_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pinwheel_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pinwheel_bus_arbiter: vector table, directed corner sequences and        |
// | randomized traffic against a queue-based reference model.                   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_pinwheel_bus_arbiter;
   localparam int MAXO = 2;
   localparam int LIM  = 4;
   localparam int SW   = 2;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   logic          m0_a_valid, m1_a_valid, slv_a_ready, slv_d_valid, slv_d_error;
   logic [2:0]    m0_a_opcode, m1_a_opcode, slv_d_opcode;
   logic [1:0]    m0_a_size, m1_a_size, slv_d_size;
   logic [SW-1:0] m0_a_source, m1_a_source;
   logic [31:0]   m0_a_address, m1_a_address, m0_a_data, m1_a_data, slv_d_data;
   logic [3:0]    m0_a_mask, m1_a_mask;

   logic          m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid, m0_d_error, m1_d_error;
   logic [2:0]    m0_d_opcode, m1_d_opcode, slv_a_opcode;
   logic [1:0]    m0_d_size, m1_d_size, slv_a_size;
   logic [SW-1:0] m0_d_source, m1_d_source, slv_a_source;
   logic [31:0]   m0_d_data, m1_d_data, slv_a_address, slv_a_data;
   logic [3:0]    slv_a_mask;
   logic          slv_a_valid, busy, err_spurious;
`ifdef PINWHEEL_ARB_STATS_EN
   logic [15:0]   stat_gnt0, stat_gnt1, stat_force;
`endif

   pinwheel_bus_arbiter #(
      .MAX_OUTSTANDING(MAXO),
      .STARVE_LIMIT   (LIM),
      .SRC_WIDTH      (SW)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .m0_a_valid_i   (m0_a_valid),
      .m0_a_opcode_i  (m0_a_opcode),
      .m0_a_size_i    (m0_a_size),
      .m0_a_source_i  (m0_a_source),
      .m0_a_address_i (m0_a_address),
      .m0_a_mask_i    (m0_a_mask),
      .m0_a_data_i    (m0_a_data),
      .m0_a_ready_o   (m0_a_ready),
      .m0_d_valid_o   (m0_d_valid),
      .m0_d_opcode_o  (m0_d_opcode),
      .m0_d_size_o    (m0_d_size),
      .m0_d_source_o  (m0_d_source),
      .m0_d_data_o    (m0_d_data),
      .m0_d_error_o   (m0_d_error),
      .m1_a_valid_i   (m1_a_valid),
      .m1_a_opcode_i  (m1_a_opcode),
      .m1_a_size_i    (m1_a_size),
      .m1_a_source_i  (m1_a_source),
      .m1_a_address_i (m1_a_address),
      .m1_a_mask_i    (m1_a_mask),
      .m1_a_data_i    (m1_a_data),
      .m1_a_ready_o   (m1_a_ready),
      .m1_d_valid_o   (m1_d_valid),
      .m1_d_opcode_o  (m1_d_opcode),
      .m1_d_size_o    (m1_d_size),
      .m1_d_source_o  (m1_d_source),
      .m1_d_data_o    (m1_d_data),
      .m1_d_error_o   (m1_d_error),
      .slv_a_valid_o  (slv_a_valid),
      .slv_a_opcode_o (slv_a_opcode),
      .slv_a_size_o   (slv_a_size),
      .slv_a_source_o (slv_a_source),
      .slv_a_address_o(slv_a_address),
      .slv_a_mask_o   (slv_a_mask),
      .slv_a_data_o   (slv_a_data),
      .slv_a_ready_i  (slv_a_ready),
      .slv_d_valid_i  (slv_d_valid),
      .slv_d_opcode_i (slv_d_opcode),
      .slv_d_size_i   (slv_d_size),
      .slv_d_data_i   (slv_d_data),
      .slv_d_error_i  (slv_d_error),
`ifdef PINWHEEL_ARB_STATS_EN
      .stat_gnt0_o    (stat_gnt0),
      .stat_gnt1_o    (stat_gnt1),
      .stat_force_o   (stat_force),
`endif
      .busy_o         (busy),
      .err_spurious_o (err_spurious)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: queue of outstanding {master, original source}, starvation age, sticky error.
   typedef struct packed { bit idx; bit [SW-1:0] src; } ent_t;
   ent_t mq[$];
   int   m_starve;
   bit   m_err;

   bit            obs_g0, obs_g1, obs_d0, obs_d1, obs_busy;
   bit [SW-1:0]   obs_dsrc;
   int            m0_resp, m1_resp;

   typedef struct {
      bit m0v; bit [SW-1:0] s0; bit m1v; bit [SW-1:0] s1; bit rdy; bit dv;
      bit g0; bit g1; bit d0; bit d1; bit [SW-1:0] dsrc; bit busy;
   } vec_t;
   vec_t vt[8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive_idle();
      m0_a_valid = 0; m1_a_valid = 0; slv_a_ready = 0; slv_d_valid = 0;
      m0_a_opcode = 0; m0_a_size = 0; m0_a_source = 0; m0_a_address = 0; m0_a_mask = 0; m0_a_data = 0;
      m1_a_opcode = 0; m1_a_size = 0; m1_a_source = 0; m1_a_address = 0; m1_a_mask = 0; m1_a_data = 0;
      slv_d_opcode = 0; slv_d_size = 0; slv_d_data = 0; slv_d_error = 0;
   endtask

   // Entered and left at a falling edge; inputs that should be ignored are held high during reset.
   task automatic do_reset();
      reset_n = 1'b0;
      m0_a_valid = 1; m1_a_valid = 1; slv_a_ready = 1; slv_d_valid = 1;
      #2;
      chk("rst_m0_a_ready", m0_a_ready, 0);
      chk("rst_m1_a_ready", m1_a_ready, 0);
      chk("rst_slv_a_valid", slv_a_valid, 0);
      chk("rst_d_valid", {m0_d_valid, m1_d_valid}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_spurious, 0);
`ifdef PINWHEEL_ARB_STATS_EN
      chk("rst_stats", {stat_gnt0, stat_gnt1, stat_force}, 0);
`endif
      @(negedge clock);
      drive_idle();
      reset_n = 1'b1;
      mq.delete(); m_starve = 0; m_err = 0; m0_resp = 0; m1_resp = 0;
   endtask

   task automatic cycle(input bit m0v, input bit [SW-1:0] s0, input bit m1v,
                        input bit [SW-1:0] s1, input bit rdy, input bit dv);
      bit   can, frc, e0, e1, hit;
      ent_t h;
      m0_a_valid = m0v; m0_a_source = s0; m0_a_opcode = 3'($urandom_range(0, 4));
      m0_a_size = 2'($urandom); m0_a_address = $urandom; m0_a_mask = 4'($urandom); m0_a_data = $urandom;
      m1_a_valid = m1v; m1_a_source = s1; m1_a_opcode = 3'($urandom_range(0, 4));
      m1_a_size = 2'($urandom); m1_a_address = $urandom; m1_a_mask = 4'($urandom); m1_a_data = $urandom;
      slv_a_ready = rdy; slv_d_valid = dv; slv_d_opcode = 3'($urandom_range(0, 1));
      slv_d_size = 2'($urandom); slv_d_data = $urandom; slv_d_error = 1'($urandom);
      #2;
      can = rdy && (mq.size() < MAXO);
      frc = (m_starve >= LIM) && m1v;
      e1  = can && m1v && (frc || !m0v);
      e0  = can && m0v && !e1;
      chk("m0_a_ready", m0_a_ready, e0);
      chk("m1_a_ready", m1_a_ready, e1);
      chk("slv_a_valid", slv_a_valid, e0 | e1);
      if (e0 || e1) begin
         chk("slv_a_source", slv_a_source, e1);
         chk("slv_a_address", slv_a_address, e1 ? m1_a_address : m0_a_address);
         chk("slv_a_data", slv_a_data, e1 ? m1_a_data : m0_a_data);
         chk("slv_a_opcode", slv_a_opcode, e1 ? m1_a_opcode : m0_a_opcode);
      end
      hit = dv && (mq.size() > 0);
      h = '0;
      if (hit) h = mq[0];
      chk("m0_d_valid", m0_d_valid, hit && !h.idx);
      chk("m1_d_valid", m1_d_valid, hit && h.idx);
      if (hit) begin
         chk("d_source", h.idx ? m1_d_source : m0_d_source, h.src);
         chk("d_data", h.idx ? m1_d_data : m0_d_data, slv_d_data);
         chk("d_error", h.idx ? m1_d_error : m0_d_error, slv_d_error);
      end
      chk("busy", busy, mq.size() != 0);
      chk("err_spurious", err_spurious, m_err);
      obs_g0 = m0_a_ready; obs_g1 = m1_a_ready; obs_d0 = m0_d_valid; obs_d1 = m1_d_valid;
      obs_busy = busy; obs_dsrc = m0_d_valid ? m0_d_source : m1_d_source;
      if (m0_d_valid) m0_resp++;
      if (m1_d_valid) m1_resp++;
      if (hit) void'(mq.pop_front());
      if (dv && !hit) m_err = 1;
      if (e0 || e1) mq.push_back('{idx: e1, src: (e1 ? s1 : s0)});
      m_starve = (m1v && !e1) ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      // m0,m1,m0 interleave with full blocking, in-order routing, then idle and ready-low.
      vt[0] = '{1, 1, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0};
      vt[1] = '{0, 0, 1, 0, 1, 0,  0, 1, 0, 0, 0, 1};
      vt[2] = '{1, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1};
      vt[3] = '{1, 1, 0, 0, 1, 1,  0, 0, 1, 0, 1, 1};
      vt[4] = '{1, 1, 0, 0, 1, 1,  1, 0, 0, 1, 0, 1};
      vt[5] = '{0, 0, 0, 0, 1, 1,  0, 0, 1, 0, 1, 1};
      vt[6] = '{0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0};
      vt[7] = '{0, 0, 1, 3, 0, 0,  0, 0, 0, 0, 0, 0};

      drive_idle();
      @(negedge clock);
      do_reset();

      for (int i = 0; i < 8; i++) begin
         cycle(vt[i].m0v, vt[i].s0, vt[i].m1v, vt[i].s1, vt[i].rdy, vt[i].dv);
         chk($sformatf("vec%0d_g0", i), obs_g0, vt[i].g0);
         chk($sformatf("vec%0d_g1", i), obs_g1, vt[i].g1);
         chk($sformatf("vec%0d_d0", i), obs_d0, vt[i].d0);
         chk($sformatf("vec%0d_d1", i), obs_d1, vt[i].d1);
         chk($sformatf("vec%0d_busy", i), obs_busy, vt[i].busy);
         if (vt[i].d0 || vt[i].d1) chk($sformatf("vec%0d_dsrc", i), obs_dsrc, vt[i].dsrc);
      end

      // m0 alone with a one-cycle slave.
      do_reset();
      for (int i = 0; i < 11; i++) cycle(i < 10, SW'(i % 4), 0, 0, 1, mq.size() > 0);
      chk("m0_only_resp", m0_resp, 10);
      chk("m0_only_m1_resp", m1_resp, 0);

      // Both masters always valid: m1 is force-granted every fifth cycle.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         cycle(1, 2, 1, 1, 1, mq.size() > 0);
         chk($sformatf("starve_g1_c%0d", i), obs_g1, (i % 5) == 4);
      end
`ifdef PINWHEEL_ARB_STATS_EN
      #1;
      chk("stat_force", stat_force, 4);
      chk("stat_gnt1", stat_gnt1, 4);
      chk("stat_gnt0", stat_gnt0, 16);
`endif

      // Slave withholds D: two grants fill the FIFO, grants resume after the first response.
      do_reset();
      begin
         bit rdy_exp [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
         for (int i = 0; i < 8; i++) begin
            cycle(1, 1, 0, 0, 1, i >= 4);
            chk($sformatf("withhold_g0_c%0d", i), obs_g0, rdy_exp[i]);
         end
      end
      chk("withhold_busy", busy, 1);

      // Spurious D beat with an empty FIFO: nothing routed, sticky error until reset.
      do_reset();
      cycle(0, 0, 0, 0, 1, 1);
      chk("spur_no_d", obs_d0 | obs_d1, 0);
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1, mq.size() > 0);
      #1;
      chk("spur_sticky", err_spurious, 1);
      #1;
      do_reset();

      // Asynchronous reset mid-cycle with two responses outstanding.
      cycle(1, 0, 0, 0, 1, 0);
      cycle(1, 1, 0, 0, 1, 0);
      m0_a_valid = 1; m1_a_valid = 1; slv_a_ready = 1; slv_d_valid = 1;
      #1;
      chk("pre_rst_m0_d_valid", m0_d_valid, 1);
      chk("pre_rst_busy", busy, 1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("arst_m0_d_valid", m0_d_valid, 0);
      chk("arst_m1_d_valid", m1_d_valid, 0);
      chk("arst_a_ready", {m0_a_ready, m1_a_ready}, 0);
      chk("arst_slv_a_valid", slv_a_valid, 0);
      chk("arst_busy", busy, 0);
      @(negedge clock);
      drive_idle();
      reset_n = 1'b1;
      mq.delete(); m_starve = 0; m_err = 0;
      for (int i = 0; i < 5; i++) begin
         cycle(1, 0, 1, 0, 1, mq.size() > 0);
         chk($sformatf("post_rst_g1_c%0d", i), obs_g1, i == 4);
      end

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         bit dv;
         dv = (mq.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
         cycle(1'($urandom), SW'($urandom), 1'($urandom), SW'($urandom),
               $urandom_range(0, 3) != 0, dv);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
